// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one cache-line bus between NUM_REQ requesters (index 0 = dcache).
// Latency: grant registered 1 cycle after req_valid in IDLE; bus outputs then follow owner combinationally.
// Backpressure: memory paces beats with bus_okay; the owner holds its request until resp_last.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_*                      flattened per-requester request fields (requester i at [i*W +: W])
//   resp_ready/resp_last/data  per-requester beat return, only the owner ever sees a beat
//   bus_*                      downstream burst request and memory beat handshake
//   busy, owner, proto_err     status: burst in progress, current/last grant, sticky protocol error
module cbus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 4,
  parameter bit ROUND_ROBIN = 1'b0,
  localparam int OWN_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_is_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strobe,
  output logic [NUM_REQ-1:0]          resp_ready,
  output logic [NUM_REQ-1:0]          resp_last,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        bus_valid,
  output logic                        bus_is_write,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [LEN_W-1:0]            bus_len,
  output logic [DATA_W-1:0]           bus_data,
  output logic [DATA_W/8-1:0]         bus_strobe,
  input  logic                        bus_okay,
  input  logic                        bus_last,
  input  logic [DATA_W-1:0]           bus_rdata,
  output logic                        busy,
  output logic [OWN_W-1:0]            owner,
  output logic                        proto_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               proto_err_q, proto_err_d;

  // Owner's request fields, selected from the flattened inputs.
  logic               sel_vld;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [DATA_W-1:0]  sel_data;
  logic [DATA_W/8-1:0] sel_strb;

  logic               win_vld;
  logic [OWN_W-1:0]   win_idx;

  always_comb begin
    sel_vld  = 1'b0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWN_W'(i)) begin
        sel_vld  = req_valid[i];
        sel_wr   = req_is_write[i];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*LEN_W +: LEN_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_strb = req_strobe[i*(DATA_W/8) +: DATA_W/8];
      end
    end
  end

  // Winner search: scan starts at rr_ptr in round-robin mode, at 0 otherwise,
  // and the first asserted request in scan order wins.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ROUND_ROBIN ? ((int'(rr_ptr_q) + k) % NUM_REQ) : k;
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = OWN_W'(idx);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (bus_okay) proto_err_d = 1'b1;
        if (win_vld) begin
          owner_d = win_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Owner abandoning its request is an error, but the burst still runs to bus_last.
        if (!sel_vld) proto_err_d = 1'b1;
        if (bus_okay) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (bus_last && (beat_cnt_q != sel_len)) proto_err_d = 1'b1;
          if (!bus_last && (beat_cnt_q == sel_len)) proto_err_d = 1'b1;
          if (bus_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            if (ROUND_ROBIN) begin
              rr_ptr_d = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + OWN_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is quiet in IDLE; in BUSY the bus mirrors the owner.
  always_comb begin
    resp_ready   = '0;
    resp_last    = '0;
    resp_data    = '0;
    bus_valid    = 1'b0;
    bus_is_write = 1'b0;
    bus_addr     = '0;
    bus_len      = '0;
    bus_data     = '0;
    bus_strobe   = '0;
    if (state_q == BUSY) begin
      bus_valid    = 1'b1;
      bus_is_write = sel_wr;
      bus_addr     = sel_addr;
      bus_len      = sel_len;
      bus_data     = sel_data;
      bus_strobe   = sel_strb;
      resp_data    = bus_rdata;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == OWN_W'(i)) begin
          resp_ready[i] = bus_okay;
          resp_last[i]  = bus_okay & bus_last;
        end
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign owner     = owner_q;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed bench for cbus_arbiter, fixed-priority and round-robin instances.
// Inputs are driven 1 time unit after posedge; outputs are sampled then or at the negedge.
// Expected response beats are queued when memory beats are driven and popped when checked.
module tb_cbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_is_write;
  logic [63:0] req_addr, req_data;
  logic [7:0]  req_len, req_strobe;
  logic        bus_okay, bus_last;
  logic [31:0] bus_rdata;

  logic [1:0]  rrdy_f, rlst_f, rrdy_r, rlst_r;
  logic [31:0] rdat_f, rdat_r;
  logic        bvld_f, bwr_f, bvld_r, bwr_r;
  logic [31:0] baddr_f, baddr_r, bdat_f, bdat_r;
  logic [3:0]  blen_f, blen_r, bstrb_f, bstrb_r;
  logic        busy_f, busy_r, own_f, own_r, perr_f, perr_r;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  rdy;
    logic [1:0]  lst;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];
  int   own_q[$];

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .ROUND_ROBIN(1'b0)) dut_f (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data), .req_strobe(req_strobe),
    .resp_ready(rrdy_f), .resp_last(rlst_f), .resp_data(rdat_f),
    .bus_valid(bvld_f), .bus_is_write(bwr_f), .bus_addr(baddr_f), .bus_len(blen_f),
    .bus_data(bdat_f), .bus_strobe(bstrb_f), .bus_okay(bus_okay), .bus_last(bus_last),
    .bus_rdata(bus_rdata), .busy(busy_f), .owner(own_f), .proto_err(perr_f));

  cbus_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .ROUND_ROBIN(1'b1)) dut_r (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data), .req_strobe(req_strobe),
    .resp_ready(rrdy_r), .resp_last(rlst_r), .resp_data(rdat_r),
    .bus_valid(bvld_r), .bus_is_write(bwr_r), .bus_addr(baddr_r), .bus_len(blen_r),
    .bus_data(bdat_r), .bus_strobe(bstrb_r), .bus_okay(bus_okay), .bus_last(bus_last),
    .bus_rdata(bus_rdata), .busy(busy_r), .owner(own_r), .proto_err(perr_r));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the selected instance to go busy; returns edges taken.
  task automatic wait_grant(input bit sel, input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel ? busy_r : busy_f) && n < 8);
    chk(tag, sel ? busy_r : busy_f, 1'b1);
  endtask

  task automatic beat_drive(input logic lst, input int own);
    exp_t e;
    bus_okay  = 1'b1;
    bus_last  = lst;
    bus_rdata = $urandom;
    e.rdy = 2'b01 << own;
    e.lst = lst ? e.rdy : 2'b00;
    e.dat = bus_rdata;
    sb.push_back(e);
  endtask

  task automatic beat_check(input bit sel, input string tag);
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_rdy"}, sel ? rrdy_r : rrdy_f, e.rdy);
    chk({tag, "_last"}, sel ? rlst_r : rlst_f, e.lst);
    chk({tag, "_data"}, sel ? rdat_r : rdat_f, e.dat);
  endtask

  task automatic beat_end();
    tick();
    bus_okay = 1'b0;
    bus_last = 1'b0;
  endtask

  task automatic beat(input bit sel, input logic lst, input int own, input string tag);
    beat_drive(lst, own);
    beat_check(sel, tag);
    beat_end();
  endtask

  initial begin
    int n;
    int o;
    reset = 1'b1; req_valid = '0; req_is_write = '0; req_addr = '0; req_data = '0;
    req_len = '0; req_strobe = '0; bus_okay = 1'b0; bus_last = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_busy", busy_f, 1'b0);
    chk("rst_bus_valid", bvld_f, 1'b0);
    chk("rst_owner", own_f, 1'b0);
    chk("rst_proto_err", perr_f, 1'b0);
    chk("rst_resp_ready", rrdy_f, 2'b00);
    reset = 1'b0;
    tick();

    // 1: single 4-beat read from requester 0.
    req_valid = 2'b01; req_len[3:0] = 4'd3; req_addr[31:0] = 32'h0000_1000;
    chk("t1_idle_before_grant", busy_f, 1'b0);
    wait_grant(1'b0, "t1_grant", n);
    chk("t1_latency", n, 1);
    chk("t1_bus_valid", bvld_f, 1'b1);
    chk("t1_bus_addr", baddr_f, 32'h0000_1000);
    chk("t1_bus_len", blen_f, 4'd3);
    chk("t1_bus_is_write", bwr_f, 1'b0);
    for (int i = 0; i < 4; i++) beat(1'b0, i == 3, 0, "t1_beat");
    req_valid = 2'b00;
    chk("t1_back_idle", busy_f, 1'b0);
    chk("t1_no_err", perr_f, 1'b0);
    tick();

    // 2: simultaneous requests, fixed priority, one IDLE cycle between bursts.
    req_valid = 2'b11; req_len = 8'h00;
    req_addr = {32'h0000_3000, 32'h0000_2000};
    wait_grant(1'b0, "t2_grant0", n);
    chk("t2_owner0", own_f, 1'b0);
    chk("t2_addr0", baddr_f, 32'h0000_2000);
    beat(1'b0, 1'b1, 0, "t2_beat0");
    req_valid = 2'b10;
    chk("t2_idle_gap", busy_f, 1'b0);
    wait_grant(1'b0, "t2_grant1", n);
    chk("t2_grant1_one_edge", n, 1);
    chk("t2_owner1", own_f, 1'b1);
    chk("t2_addr1", baddr_f, 32'h0000_3000);
    beat(1'b0, 1'b1, 1, "t2_beat1");
    req_valid = 2'b00;
    tick();

    // 3: round-robin, both held for 4 two-beat bursts.
    reset = 1'b1; tick(); reset = 1'b0;
    own_q = {0, 1, 0, 1};
    req_valid = 2'b11; req_len = 8'h11;
    for (int b = 0; b < 4; b++) begin
      wait_grant(1'b1, "t3_grant", n);
      o = own_q.pop_front();
      chk("t3_owner", own_r, o[0]);
      beat(1'b1, 1'b0, o, "t3_beat");
      beat(1'b1, 1'b1, o, "t3_beat");
    end
    req_valid = 2'b00;
    chk("t3_no_err", perr_r, 1'b0);
    tick();

    // 4: two-beat write from requester 1, data and strobe follow the requester.
    req_valid = 2'b10; req_is_write = 2'b10; req_len = 8'h10;
    req_addr[63:32] = 32'h0000_4000; req_data[63:32] = 32'hAAAA_0001; req_strobe = 8'hF0;
    wait_grant(1'b0, "t4_grant", n);
    chk("t4_is_write", bwr_f, 1'b1);
    chk("t4_addr", baddr_f, 32'h0000_4000);
    chk("t4_data_a", bdat_f, 32'hAAAA_0001);
    chk("t4_strobe_a", bstrb_f, 4'hF);
    beat(1'b0, 1'b0, 1, "t4_beat");
    req_data[63:32] = 32'hBBBB_0002; req_strobe = 8'h30;
    beat_drive(1'b1, 1);
    beat_check(1'b0, "t4_beat");
    chk("t4_data_b", bdat_f, 32'hBBBB_0002);
    chk("t4_strobe_b", bstrb_f, 4'h3);
    beat_end();
    req_valid = 2'b00; req_is_write = 2'b00;
    tick();

    // 5: length error, bus_last on beat 2 of 4; next request still served.
    req_valid = 2'b01; req_len = 8'h03;
    wait_grant(1'b0, "t5_grant", n);
    beat(1'b0, 1'b0, 0, "t5_beat");
    beat(1'b0, 1'b1, 0, "t5_beat");
    req_valid = 2'b00;
    chk("t5_err_set", perr_f, 1'b1);
    chk("t5_back_idle", busy_f, 1'b0);
    tick();
    chk("t5_err_sticky", perr_f, 1'b1);
    req_valid = 2'b10; req_len = 8'h00;
    wait_grant(1'b0, "t5_regrant", n);
    chk("t5_owner1", own_f, 1'b1);
    beat(1'b0, 1'b1, 1, "t5_beat_next");
    req_valid = 2'b00;
    tick();

    // 6: reset during beat 2 of a 4-beat burst.
    req_valid = 2'b01; req_len = 8'h03;
    wait_grant(1'b0, "t6_grant", n);
    beat(1'b0, 1'b0, 0, "t6_beat");
    bus_okay = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; bus_okay = 1'b0; req_valid = 2'b00;
    chk("t6_busy", busy_f, 1'b0);
    chk("t6_bus_valid", bvld_f, 1'b0);
    chk("t6_proto_err", perr_f, 1'b0);
    chk("t6_owner", own_f, 1'b0);

    // bus_okay while IDLE is a protocol error.
    bus_okay = 1'b1;
    tick();
    bus_okay = 1'b0;
    chk("t7_idle_okay_err", perr_f, 1'b1);
    chk("t7_stays_idle", busy_f, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
